// File: rtl/cp0_exc_unit.sv
// -----------------------------------------------------------------------------
// cp0_exc_unit
// Coprocessor-0 exception/interrupt unit sitting at the MEM stage. Holds the
// SR, Cause and EPC registers, serves mtc0/mfc0/eret, and raises the
// same-cycle flush/redirect request 'req' that every pipeline register obeys.
//
// Optional feature macro: CP0_PRID_EN (when defined, CP0 register 15 reads
// PRID_VAL; when undefined, register 15 reads 0 and no PRId logic exists).
//
// Ports:
//   clk          in   1   clock
//   reset        in   1   synchronous, active-high reset
//   en           in   1   mtc0 write enable
//   cp0_addr     in   5   CP0 register number (12 SR, 13 Cause, 14 EPC, 15 PRId)
//   cp0_wdata    in  32   mtc0 write data
//   cp0_rdata    out 32   mfc0 read data (combinational)
//   vpc          in  32   PC of the MEM-stage instruction
//   bd_in        in   1   MEM-stage instruction sits in a branch delay slot
//   exc_code_in  in   5   exception code from MEM, 0 = none
//   exl_clr      in   1   eret in MEM
//   hw_int       in   6   external interrupt lines
//   req          out  1   exception/interrupt taken this cycle (flush)
//   handler_pc   out 32   exception handler entry PC (constant)
//   epc_out      out 32   current EPC, the eret target
// -----------------------------------------------------------------------------
module cp0_exc_unit #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
   parameter logic [31:0] PRID_VAL     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   input  logic [31:0] vpc,
   input  logic        bd_in,
   input  logic [4:0]  exc_code_in,
   input  logic        exl_clr,
   input  logic [5:0]  hw_int,
   output logic        req,
   output logic [31:0] handler_pc,
   output logic [31:0] epc_out
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;

   // Architectural state
   logic [5:0]  r_sr_im;
   logic        r_sr_exl;
   logic        r_sr_ie;
   logic        r_cause_bd;
   logic [5:0]  r_cause_ip;
   logic [4:0]  r_cause_exc;
   logic [31:0] r_epc;

   logic        w_int_req;
   logic        w_exc_req;
   logic        w_req;
   logic [31:0] w_sr_word;
   logic [31:0] w_cause_word;
   logic [31:0] w_epc_next;

   // EXL masks both sources, so a handler is never re-entered.
   assign w_int_req = (|(hw_int & r_sr_im)) & r_sr_ie & ~r_sr_exl;
   assign w_exc_req = (exc_code_in != 5'd0) & ~r_sr_exl;
   assign w_req     = w_int_req | w_exc_req;

   // A delay-slot instruction restarts at its branch, one word earlier.
   assign w_epc_next = bd_in ? (vpc - 32'd4) : vpc;

   assign w_sr_word    = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
   assign w_cause_word = {r_cause_bd, 15'd0, r_cause_ip, 3'd0, r_cause_exc, 2'd0};

   assign req        = w_req;
   assign handler_pc = HANDLER_ADDR;
   assign epc_out    = r_epc;

   // CP0 register update: exception entry, mtc0 writes, eret and IP sampling.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sr_im     <= 6'd0;
         r_sr_exl    <= 1'b0;
         r_sr_ie     <= 1'b0;
         r_cause_bd  <= 1'b0;
         r_cause_ip  <= 6'd0;
         r_cause_exc <= 5'd0;
         r_epc       <= 32'd0;
      end else begin
         // IP is a live mirror of the interrupt lines, independent of req.
         r_cause_ip <= hw_int;
         if (w_req) begin
            // Exception entry swallows any mtc0/eret issued in this cycle.
            r_sr_exl    <= 1'b1;
            r_cause_exc <= w_int_req ? 5'd0 : exc_code_in;
            r_cause_bd  <= bd_in;
            r_epc       <= w_epc_next;
         end else begin
            if (en) begin
               case (cp0_addr)
                  ADDR_SR: begin
                     r_sr_im  <= cp0_wdata[15:10];
                     r_sr_exl <= cp0_wdata[1];
                     r_sr_ie  <= cp0_wdata[0];
                  end
                  ADDR_EPC: begin
                     r_epc <= cp0_wdata;
                  end
                  default: begin
                     // Cause, PRId and unimplemented registers are not writable.
                  end
               endcase
            end
            // Placed after the mtc0 decode so eret wins the EXL bit.
            if (exl_clr) begin
               r_sr_exl <= 1'b0;
            end
         end
      end
   end

`ifdef CP0_PRID_EN
   logic [31:0] w_prid_word;
   assign w_prid_word = PRID_VAL;
`else
   logic w_unused_prid;
   assign w_unused_prid = ^PRID_VAL;
`endif

   // mfc0 read mux; unimplemented registers read as zero.
   always_comb begin
      cp0_rdata = 32'd0;
      case (cp0_addr)
         ADDR_SR:    cp0_rdata = w_sr_word;
         ADDR_CAUSE: cp0_rdata = w_cause_word;
         ADDR_EPC:   cp0_rdata = r_epc;
`ifdef CP0_PRID_EN
         ADDR_PRID:  cp0_rdata = w_prid_word;
`else
         ADDR_PRID:  cp0_rdata = 32'd0;
`endif
         default:    cp0_rdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;

   localparam logic [31:0] HANDLER = 32'h0000_4180;
   localparam logic [31:0] PRID    = 32'h0001_8000;

   localparam int SEL_REQ   = 0;
   localparam int SEL_RDATA = 1;
   localparam int SEL_EPC   = 2;
   localparam int SEL_HPC   = 3;

   logic        clk;
   logic        reset;
   logic        en;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic [31:0] vpc;
   logic        bd_in;
   logic [4:0]  exc_code_in;
   logic        exl_clr;
   logic [5:0]  hw_int;
   logic        req;
   logic [31:0] handler_pc;
   logic [31:0] epc_out;

   cp0_exc_unit #(.HANDLER_ADDR(HANDLER), .PRID_VAL(PRID)) dut (
      .clk(clk), .reset(reset), .en(en), .cp0_addr(cp0_addr),
      .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .vpc(vpc),
      .bd_in(bd_in), .exc_code_in(exc_code_in), .exl_clr(exl_clr),
      .hw_int(hw_int), .req(req), .handler_pc(handler_pc), .epc_out(epc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   // Expectations are queued by the stimulus; the monitor pops them at negedge.
   task automatic expect_val(input string nm, input int sel, input logic [31:0] exp);
      exp_t e;
      e.nm = nm; e.sel = sel; e.exp = exp;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'd0; vpc = 32'd0;
      bd_in = 1'b0; exc_code_in = 5'd0; exl_clr = 1'b0;
   endtask

   // Monitor: compare every queued expectation against the DUT mid-cycle.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (q.size() > 0) begin
         e = q.pop_front();
         case (e.sel)
            SEL_REQ:   act = {31'd0, req};
            SEL_RDATA: act = cp0_rdata;
            SEL_EPC:   act = epc_out;
            default:   act = handler_pc;
         endcase
         n_cmp++;
         if (act !== e.exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
         end
      end
   end

   initial begin
      logic [31:0] prid_exp;
`ifdef CP0_PRID_EN
      prid_exp = PRID;
`else
      prid_exp = 32'd0;
`endif
      reset = 1'b1; hw_int = 6'd0; idle();
      tick(); tick();
      reset = 1'b0;

      // Reset state; IP still 0 because the last edge was a reset edge.
      hw_int = 6'b000001; cp0_addr = 5'd13;
      expect_val("rst_req", SEL_REQ, 32'd0);
      expect_val("rst_cause", SEL_RDATA, 32'd0);
      expect_val("rst_epc", SEL_EPC, 32'd0);
      expect_val("handler_pc", SEL_HPC, HANDLER);
      tick();
      cp0_addr = 5'd12;
      expect_val("rst_sr", SEL_RDATA, 32'd0);
      expect_val("int_disabled_req", SEL_REQ, 32'd0);
      tick();
      cp0_addr = 5'd13; hw_int = 6'd0;
      expect_val("ip_mirror", SEL_RDATA, 32'h0000_0400);
      tick();

      // mtc0 SR, then an interrupt on line 2.
      en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01;
      tick();
      idle(); hw_int = 6'b000100; vpc = 32'h0000_3010; cp0_addr = 5'd12;
      expect_val("int_req", SEL_REQ, 32'd1);
      expect_val("sr_written", SEL_RDATA, 32'h0000_FC01);
      tick();
      cp0_addr = 5'd12;
      expect_val("int_masked_req", SEL_REQ, 32'd0);
      expect_val("int_epc", SEL_EPC, 32'h0000_3010);
      expect_val("int_sr_exl", SEL_RDATA, 32'h0000_FC03);
      tick();
      hw_int = 6'd0; cp0_addr = 5'd13;
      expect_val("int_cause", SEL_RDATA, 32'h0000_1000);
      tick();

      // eret with simultaneous SR write of IE=0; EXL cleared despite wdata.
      exl_clr = 1'b1; en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC02;
      tick();
      idle(); exc_code_in = 5'd10; vpc = 32'h0000_3024; bd_in = 1'b1; cp0_addr = 5'd12;
      expect_val("eret_sr", SEL_RDATA, 32'h0000_FC00);
      expect_val("exc_req", SEL_REQ, 32'd1);
      tick();

      // Exception under EXL is masked.
      exc_code_in = 5'd4; vpc = 32'h0000_3100; bd_in = 1'b0; cp0_addr = 5'd13;
      expect_val("bd_epc", SEL_EPC, 32'h0000_3020);
      expect_val("bd_cause", SEL_RDATA, 32'h8000_0028);
      expect_val("nested_req", SEL_REQ, 32'd0);
      tick();
      exl_clr = 1'b1; cp0_addr = 5'd12;
      expect_val("masked_epc", SEL_EPC, 32'h0000_3020);
      expect_val("pre_eret_sr", SEL_RDATA, 32'h0000_FC02);
      expect_val("eret_cycle_req", SEL_REQ, 32'd0);
      tick();
      exl_clr = 1'b0;
      expect_val("post_eret_req", SEL_REQ, 32'd1);
      tick();
      exc_code_in = 5'd0; cp0_addr = 5'd13;
      expect_val("exc4_epc", SEL_EPC, 32'h0000_3100);
      expect_val("exc4_cause", SEL_RDATA, 32'h0000_0010);
      tick();

      // mtc0 EPC in the same cycle as a request: request wins.
      exl_clr = 1'b1;
      tick();
      idle(); en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3ABC;
      exc_code_in = 5'd12; vpc = 32'h0000_3000;
      expect_val("epc_race_req", SEL_REQ, 32'd1);
      expect_val("epc_old_read", SEL_RDATA, 32'h0000_3100);
      tick();
      idle(); cp0_addr = 5'd13;
      expect_val("epc_race_epc", SEL_EPC, 32'h0000_3000);
      expect_val("exc12_cause", SEL_RDATA, 32'h0000_0030);
      tick();
      en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3ABC;
      expect_val("epc_wr_req", SEL_REQ, 32'd0);
      tick();
      en = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
      expect_val("epc_wr_epc", SEL_EPC, 32'h0000_3ABC);
      tick();
      idle(); cp0_addr = 5'd14;
      expect_val("epc_wr_read", SEL_RDATA, 32'h0000_3ABC);
      tick();
      cp0_addr = 5'd13;
      expect_val("cause_ro", SEL_RDATA, 32'h0000_0030);
      tick();
      cp0_addr = 5'd15;
      expect_val("prid_read", SEL_RDATA, prid_exp);
      tick();
      cp0_addr = 5'd3;
      expect_val("unimpl_read", SEL_RDATA, 32'd0);
      tick();

      // Reset while EXL=1 with live inputs.
      reset = 1'b1; exc_code_in = 5'd5; hw_int = 6'h3F;
      tick();
      reset = 1'b0; idle(); hw_int = 6'd0; cp0_addr = 5'd12;
      expect_val("mid_rst_sr", SEL_RDATA, 32'd0);
      expect_val("mid_rst_epc", SEL_EPC, 32'd0);
      expect_val("mid_rst_req", SEL_REQ, 32'd0);
      tick();
      cp0_addr = 5'd13;
      expect_val("mid_rst_cause", SEL_RDATA, 32'd0);
      tick();

      // Interrupt and exception together, delay slot at PC 0 (wraps).
      en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01;
      tick();
      idle(); hw_int = 6'b000001; exc_code_in = 5'd10; bd_in = 1'b1; vpc = 32'd0;
      expect_val("prio_req", SEL_REQ, 32'd1);
      tick();
      idle(); cp0_addr = 5'd13;
      expect_val("prio_cause", SEL_RDATA, 32'h8000_0400);
      expect_val("wrap_epc", SEL_EPC, 32'hFFFF_FFFC);
      tick();

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_mis++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 exception/interrupt unit at the MEM stage.
- Generates the `req` flush/redirect request consumed by all pipeline registers. On `req`, the MEM/WB register loads PC `HANDLER_ADDR` and a zero instruction.
- Holds the SR, Cause and EPC state, and serves `mtc0`, `mfc0` and `eret`.
- It is the initiator of the `req` protocol; the pipeline registers are its responders.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, exception handler entry PC; driven on `handler_pc` for the PC/MEM_WB flush.
- PRID_VAL, 32'h0000_0000, value of the PRId register (used only with CP0_PRID_EN).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- en  input  1  `mtc0` write enable (MEM-stage `mtc0`).
- cp0_addr  input  5  CP0 register number: 12 = SR, 13 = Cause, 14 = EPC, 15 = PRId.
- cp0_wdata  input  32  `mtc0` data.
- cp0_rdata  output  32  `mfc0` read data, combinational.
- vpc  input  32  PC of the MEM-stage instruction (macro PC).
- bd_in  input  1  MEM-stage instruction is in a branch delay slot.
- exc_code_in  input  5  exception code from MEM; 0 = no exception.
- exl_clr  input  1  `eret` in MEM.
- hw_int  input  6  external interrupt lines.
- req  output  1  exception/interrupt taken this cycle; flush request.
- handler_pc  output  32  constant HANDLER_ADDR.
- epc_out  output  32  current EPC, used as the `eret` target.

Behaviour:
- Register fields:
  - SR: IM = [15:10], EXL = [1], IE = [0]; other bits read 0.
  - Cause: BD = [31], IP = [15:10], ExcCode = [6:2]; other bits read 0.
  - EPC: 32-bit.
- Reset (synchronous): SR, Cause and EPC become 0. Outputs after reset: `req` = 0, `epc_out` = 0, `cp0_rdata` = 0.
- Request logic (combinational):
  - int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL
  - exc_req = (exc_code_in != 0) & ~SR.EXL
  - req = int_req | exc_req
  - `req` has zero latency; it is asserted in the same cycle the condition holds.
- Cause.IP samples `hw_int` at every posedge, including while `req` is high. It is not writable by `mtc0`.
- On a posedge with req = 1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_req ? 0 : exc_code_in (interrupt has priority).
  - Cause.BD <= bd_in.
  - EPC <= bd_in ? vpc - 4 : vpc, computed modulo 2^32.
  - Any `mtc0` or `eret` in the same cycle is ignored.
- On a posedge with req = 0 and exl_clr = 1: SR.EXL <= 0. A simultaneous `mtc0` is still applied; on an SR write, EXL is cleared regardless of wdata[1].
- On a posedge with req = 0 and en = 1, `mtc0` writes by address:
  - 12: IM, EXL and IE from wdata.
  - 13: read-only; write ignored.
  - 14: EPC <= wdata (full 32 bits).
  - Other addresses: write ignored.
- Reads: `cp0_rdata` = register selected by `cp0_addr`; unimplemented addresses read 0. A read in the same cycle as a write returns the old value.
- While EXL = 1, every request is masked: nested exceptions are not taken and `req` stays 0.
- Reset has priority over everything, including a pending `req` (mid-handler reset included).
- `exc_code_in` is don't-care when req is masked.

Optional Feature:
- Macro CP0_PRID_EN.
- Defined: address 15 reads PRID_VAL; `mtc0` to address 15 is ignored.
- Undefined: address 15 reads 0 and no PRId logic is generated.

Test Plan:
- Reset, then SR=0, hw_int=6'b000001 -> req=0; at next edge Cause reads 32'h0000_0400, i.e. IP mirrors hw_int even with interrupts disabled.
- `mtc0` SR=32'h0000_FC01, hw_int[2]=1, vpc=32'h3010, bd_in=0 -> req=1 combinationally. After the edge: EPC=32'h3010, SR=32'h0000_FC03, ExcCode=0, and req drops since EXL=1.
- EXL=0, IE=0, exc_code_in=5'd10, vpc=32'h3024, bd_in=1 -> req=1. After the edge: EPC=32'h3020, Cause=32'h8000_0028.
- EXL=1, exc_code_in=5'd4 -> req=0 with EPC unchanged. Then exl_clr=1 -> EXL=0 at the edge, and req rises if exc_code_in is still nonzero.
- en=1, cp0_addr=14, cp0_wdata=32'h0000_3ABC, with req forced the same cycle (exc_code_in=5'd12, vpc=32'h3000) -> EPC=32'h3000 (req wins). A repeat with req=0 -> EPC=32'h0000_3ABC and epc_out matches.
- Read cp0_addr=15 -> PRID_VAL with CP0_PRID_EN, 0 without. Assert reset while EXL=1 -> SR, Cause and EPC all 0 after the edge.
